// File: rtl/frame_unpack.sv
// Deframer for the packed frame stream: decodes the header into a load/save
// instruction pulse and forwards data beats through a one-entry output register.
module frame_unpack #(
  parameter int DATAWIDTH    = 512,
  parameter int LOAD_INS_LEN = 96,
  parameter int SAVE_INS_LEN = 128,
  parameter int TYPE_LSB     = 128,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATAWIDTH-1:0]    in_data,
  input  logic                    in_last,
  output logic                    load_ins_valid,
  output logic [LOAD_INS_LEN-1:0] load_ins_data,
  output logic                    save_ins_valid,
  output logic [SAVE_INS_LEN-1:0] save_ins_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATAWIDTH-1:0]    out_data,
  output logic                    out_last,
  output logic [CNT_W-1:0]        beat_count,
  output logic                    done,
  output logic                    err
);

  localparam logic [1:0] ST_HDR   = 2'd0;
  localparam logic [1:0] ST_BODY  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_SKIP  = 2'd3;

  logic [1:0] state;
  logic [1:0] hdr_type;
  logic       is_load;
  logic       is_save;
  logic       in_fire;
  logic       out_fire;

  assign hdr_type = in_data[TYPE_LSB+1:TYPE_LSB];
  assign is_load  = (hdr_type == 2'b01);
  assign is_save  = (hdr_type == 2'b10);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_HDR:   in_ready = 1'b1;
      ST_BODY:  in_ready = !out_valid || out_ready;
      ST_FLUSH: in_ready = 1'b0;
      ST_SKIP:  in_ready = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_HDR;
      load_ins_valid <= 1'b0;
      load_ins_data  <= '0;
      save_ins_valid <= 1'b0;
      save_ins_data  <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last       <= 1'b0;
      beat_count     <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      load_ins_valid <= 1'b0;
      save_ins_valid <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      // a beat accepted in the same cycle below overrides this clear
      if (out_fire) out_valid <= 1'b0;

      case (state)
        ST_HDR: begin
          if (in_fire) begin
            beat_count <= '0;
            if (is_load) begin
              load_ins_data  <= in_data[LOAD_INS_LEN-1:0];
              load_ins_valid <= 1'b1;
            end
            if (is_save) begin
              save_ins_data  <= in_data[SAVE_INS_LEN-1:0];
              save_ins_valid <= 1'b1;
            end
            if (is_load || is_save) begin
              if (in_last) done <= 1'b1;
              else         state <= ST_BODY;
            end else begin
              err <= 1'b1;
              if (!in_last) state <= ST_SKIP;
            end
          end
        end
        ST_BODY: begin
          if (in_fire) begin
            out_data  <= in_data;
            out_last  <= in_last;
            out_valid <= 1'b1;
            if (beat_count != '1) beat_count <= beat_count + CNT_W'(1);
            if (in_last) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (out_fire && out_last) begin
            done  <= 1'b1;
            state <= ST_HDR;
          end
        end
        ST_SKIP: begin
          if (in_fire && in_last) state <= ST_HDR;
        end
        default: state <= ST_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_unpack.sv
// Randomized frame traffic against a frame-level reference model for frame_unpack.
module tb_frame_unpack;

  localparam int DW = 512;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic           in_last;
  logic           load_ins_valid;
  logic [95:0]    load_ins_data;
  logic           save_ins_valid;
  logic [127:0]   save_ins_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [DW-1:0]  out_data;
  logic           out_last;
  logic [15:0]    beat_count;
  logic           done;
  logic           err;

  frame_unpack #(
    .DATAWIDTH(512), .LOAD_INS_LEN(96), .SAVE_INS_LEN(128), .TYPE_LSB(128), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .load_ins_valid(load_ins_valid), .load_ins_data(load_ins_data),
    .save_ins_valid(save_ins_valid), .save_ins_data(save_ins_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .beat_count(beat_count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int or_mode = 0;   // 0: always ready, 1: random, 2: held low

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // observation side: what the DUT actually produced
  logic [DW:0]   obs_beats[$];
  logic [95:0]   obs_load[$];
  logic [127:0]  obs_save[$];
  int done_cnt = 0, err_cnt = 0, ov_cnt = 0;
  int done_cyc = 0, load_cyc = 0, save_cyc = 0, last_hs_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        obs_beats.push_back({out_last, out_data});
        last_hs_cyc = cyc;
      end
      if (out_valid) ov_cnt++;
      if (load_ins_valid) begin obs_load.push_back(load_ins_data); load_cyc = cyc; end
      if (save_ins_valid) begin obs_save.push_back(save_ins_data); save_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) err_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // reference state: held instruction registers
  logic [95:0]  exp_load = '0;
  logic [127:0] exp_save = '0;

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic last, output int acc_cyc);
    logic r;
    int   c;
    acc_cyc  = -1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      r = in_ready;
      c = cyc;
      @(posedge clk);
      #1;
      if (r) begin
        acc_cyc = c + 1;
        break;
      end
    end
    if (acc_cyc < 0) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [DW-1:0] hdr, input int n);
    logic [1:0]    typ;
    logic          is_valid;
    logic [DW-1:0] d[$];
    int            hdr_cyc, tmp;
    typ      = hdr[129:128];
    is_valid = (typ == 2'b01) || (typ == 2'b10);
    obs_beats.delete(); obs_load.delete(); obs_save.delete();
    done_cnt = 0; err_cnt = 0; ov_cnt = 0;
    for (int i = 0; i < n; i++) d.push_back(rand512());
    if (typ == 2'b01) exp_load = hdr[95:0];
    if (typ == 2'b10) exp_save = hdr[127:0];

    send_beat(hdr, n == 0, hdr_cyc);
    for (int i = 0; i < n; i++) send_beat(d[i], i == n - 1, tmp);
    for (int t = 0; t < 300 && (done_cnt + err_cnt) == 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;

    chk("done_cnt", done_cnt, is_valid ? 1 : 0);
    chk("err_cnt", err_cnt, is_valid ? 0 : 1);
    chk("load_pulses", obs_load.size(), (typ == 2'b01) ? 1 : 0);
    chk("save_pulses", obs_save.size(), (typ == 2'b10) ? 1 : 0);
    chk("load_held", load_ins_data, exp_load);
    chk("save_held", save_ins_data, exp_save);
    if (obs_load.size() == 1) begin
      chk("load_data", obs_load[0], hdr[95:0]);
      chk("load_latency", load_cyc, hdr_cyc);
    end
    if (obs_save.size() == 1) begin
      chk("save_data", obs_save[0], hdr[127:0]);
      chk("save_latency", save_cyc, hdr_cyc);
    end
    chk("beat_total", obs_beats.size(), is_valid ? n : 0);
    for (int i = 0; i < n && i < obs_beats.size(); i++) begin
      chk("beat_data", obs_beats[i][DW-1:0], d[i]);
      chk("beat_last", obs_beats[i][DW], (i == n - 1) ? 1 : 0);
    end
    chk("beat_count", beat_count, is_valid ? n : 0);
    if (!is_valid) chk("skip_no_out", ov_cnt, 0);
    if (is_valid && done_cnt == 1) begin
      if (n == 0) chk("done_latency_hdr", done_cyc, hdr_cyc);
      else        chk("done_latency_body", done_cyc, last_hs_cyc + 1);
    end
  endtask

  function automatic logic [DW-1:0] mk_hdr(input logic [1:0] typ);
    logic [DW-1:0] h;
    h = rand512();
    h[129:128] = typ;
    return h;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_beat_count"}, beat_count, 0);
    chk({tag, "_load_data"}, load_ins_data, 0);
    chk({tag, "_save_data"}, save_ins_data, 0);
    chk({tag, "_pulses"}, {load_ins_valid, save_ins_valid, done, err}, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [DW-1:0] h;
    logic [1:0]    typs[4];
    int            tmp;
    typs[0] = 2'b01; typs[1] = 2'b10; typs[2] = 2'b11; typs[3] = 2'b00;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // load header with A5 pattern and three data beats
    h = mk_hdr(2'b01);
    h[95:0] = {12{8'hA5}};
    run_frame(h, 3);

    // save header alone
    run_frame(mk_hdr(2'b10), 0);

    // invalid header skipped, then a valid one
    run_frame(mk_hdr(2'b11), 2);
    run_frame(mk_hdr(2'b01), 2);

    // four cycles of downstream stall mid-frame
    fork
      run_frame(mk_hdr(2'b10), 7);
      begin
        repeat (4) @(posedge clk);
        or_mode = 2;
        repeat (4) @(posedge clk);
        or_mode = 0;
      end
    join

    // reset while a data beat sits in the output register
    or_mode = 2;
    @(posedge clk); #1;
    send_beat(mk_hdr(2'b01), 1'b0, tmp);
    send_beat(rand512(), 1'b0, tmp);
    chk("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("mid_rst");
    exp_load = '0;
    exp_save = '0;
    rst = 1'b0;
    or_mode = 0;
    done_cnt = 0; err_cnt = 0;
    repeat (3) @(posedge clk); #1;
    chk("no_stray_done", done_cnt + err_cnt, 0);
    run_frame(mk_hdr(2'b10), 2);

    // consecutive frames
    run_frame(mk_hdr(2'b01), 1);
    run_frame(mk_hdr(2'b10), 2);

    // random traffic with random downstream backpressure
    or_mode = 1;
    for (int f = 0; f < 24; f++) begin
      h = mk_hdr(typs[$urandom_range(0, 3)]);
      run_frame(h, $urandom_range(0, 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
